spi_slave_8363: RTL and testbench
=================================

SPI_SLAVE_8363 -- requirements
Module: spi_slave_8363

Interface
REQ-001 SHALL have parameter ID_VALUE, default 8'h63, value returned by read-only register 3.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk/csb/sdi.
REQ-003 SHALL have port main_clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  SPI clock from initiator, asynchronous to main_clk.
REQ-006 SHALL have port csb  input  1  SPI chip select, active-low.
REQ-007 SHALL have port sdi  input  1  SPI serial data in, MSB first.
REQ-008 SHALL have port sdo  output  1  SPI serial data out, valid only when sdo_oe=1.
REQ-009 SHALL have port sdo_oe  output  1  output enable for the external sdio tristate.
REQ-010 SHALL have port gain_a  output  8  register 0 contents.
REQ-011 SHALL have port gain_b  output  8  register 1 contents.
REQ-012 SHALL have port ctrl  output  8  register 2 contents.
REQ-013 SHALL have port wr_stb  output  1  one-cycle pulse per accepted write.
REQ-014 SHALL have port wr_addr  output  7  address of the last accepted write.

Function
REQ-015 SHALL pass sclk, csb, sdi through SYNC_STAGES flops each; all edges detected on synchronized signals; main_clk >= 4x sclk is a requirement on the system.
REQ-016 Frame SHALL be 16 bits: bit15 R/W (1=read), bits14:8 address, bits7:0 data; sdi sampled on synchronized sclk rising edge.
REQ-017 SHALL implement FSM IDLE, CMD, DATA, WAIT.
REQ-018 IDLE -> CMD on synchronized csb falling edge; bit counter cleared to 0.
REQ-019 CMD: shift 8 bits; after 8th rising edge latch rw/address, go DATA.
REQ-020 DATA write: shift 8 bits; after 16th rising edge, if address <= 2, update register and pulse wr_stb exactly one cycle later; go WAIT.
REQ-021 Write to address 3 or > 3 SHALL change no register and produce no wr_stb.
REQ-022 DATA read: read data selected at CMD->DATA transition (reg0-2, ID_VALUE for 3, 8'h00 for >3); sdo = bit7 on first synchronized sclk falling edge after 8th rising edge, next bit on each later falling edge; go WAIT after 16th rising edge.
REQ-023 sdo_oe SHALL be 1 from that first falling edge until csb synchronized high; 0 at all other times; sdo = 0 when sdo_oe = 0.
REQ-024 WAIT: ignore further sclk edges; -> IDLE on synchronized csb rising edge.
REQ-025 csb rising in CMD or DATA SHALL abort: -> IDLE, no register update, no wr_stb, sdo_oe = 0 next cycle.
REQ-026 csb falling and sclk rising detected in same cycle: frame start takes effect; that sclk edge SHALL be sampled as bit15.
REQ-027 sclk edges while csb synchronized high SHALL be ignored.

Reset
REQ-028 rst low SHALL asynchronously force: FSM IDLE, counter 0, gain_a=8'h00, gain_b=8'h00, ctrl=8'h01, wr_stb=0, wr_addr=0, sdo=0, sdo_oe=0, synchronizers to csb=1/sclk=0/sdi=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, frame restarts only on a new csb falling edge.

Verification
REQ-030 Write 0x00/0x5A (frame 16'h005A), sclk = main_clk/8 -> gain_a=8'h5A, wr_stb one pulse, wr_addr=0, sdo_oe stays 0.
REQ-031 Read address 3 (16'h8300) -> sdo shifts 0,1,1,0,0,0,1,1 (8'h63) on bits 7..0, sdo_oe=1 until csb high.
REQ-032 Write 16'h0277 then read 16'h8200 -> ctrl=8'h77, read returns 8'h77; write 16'h03FF -> no wr_stb, ID still 8'h63.
REQ-033 csb raised after 12 bits of write 16'h01AA -> gain_b remains 8'h00, no wr_stb, FSM IDLE.
REQ-034 20 sclk pulses in one write frame 16'h0011 -> gain_a=8'h11 from first 16 bits, extra 4 bits ignored.
REQ-035 rst asserted after 10 bits of a write, released, then full frame 16'h0133 -> gain_b=8'h33, all reset values otherwise.

Source files
------------

// File: rtl/spi_slave_8363.sv
// SPI register slave: 16-bit frames, three R/W registers plus a read-only ID.
// All SPI pins are resynchronized into main_clk before edge detection.
module spi_slave_8363 #(
    parameter logic [7:0] ID_VALUE    = 8'h63,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       main_clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] gain_a,
    output logic [7:0] gain_b,
    output logic [7:0] ctrl,
    output logic       wr_stb,
    output logic [6:0] wr_addr
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sy, csb_sy, sdi_sy;
    logic       sclk_s, csb_s, sdi_s;
    logic       sclk_d, csb_d;
    logic       sclk_rise, sclk_fall, csb_rise, csb_fall;
    logic [4:0] cnt;
    logic [6:0] sr;
    logic [7:0] cur_byte;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] rd_shift;
    logic [7:0] rd_sel;
    logic       take, start, cmd_done, frame_done;

    assign sclk_s = sclk_sy[SYNC_STAGES-1];
    assign csb_s  = csb_sy[SYNC_STAGES-1];
    assign sdi_s  = sdi_sy[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csb_rise  = csb_s & ~csb_d;
    assign csb_fall  = ~csb_s & csb_d;

    assign cur_byte = {sr, sdi_s};

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            sclk_sy <= '0;
            csb_sy  <= '1;
            sdi_sy  <= '0;
            sclk_d  <= 1'b0;
            csb_d   <= 1'b1;
        end else begin
            sclk_sy[0] <= sclk;
            csb_sy[0]  <= csb;
            sdi_sy[0]  <= sdi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sy[i] <= sclk_sy[i-1];
                csb_sy[i]  <= csb_sy[i-1];
                sdi_sy[i]  <= sdi_sy[i-1];
            end
            sclk_d <= sclk_s;
            csb_d  <= csb_s;
        end
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // A frame start may coincide with the first sclk rise; that bit is bit15.
    always_comb begin
        state_nx   = state;
        take       = 1'b0;
        start      = 1'b0;
        cmd_done   = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (csb_fall) begin
                    state_nx = CMD;
                    start    = 1'b1;
                    take     = sclk_rise;
                end
            end
            CMD: begin
                if (csb_rise) begin
                    state_nx = IDLE;
                end else if (sclk_rise) begin
                    take = 1'b1;
                    if (cnt == 5'd7) begin
                        cmd_done = 1'b1;
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (csb_rise) begin
                    state_nx = IDLE;
                end else if (sclk_rise) begin
                    take = 1'b1;
                    if (cnt == 5'd15) begin
                        frame_done = 1'b1;
                        state_nx   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (csb_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_sel = 8'h00;
        case (cur_byte[6:0])
            7'd0:    rd_sel = gain_a;
            7'd1:    rd_sel = gain_b;
            7'd2:    rd_sel = ctrl;
            7'd3:    rd_sel = ID_VALUE;
            default: rd_sel = 8'h00;
        endcase
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            sr       <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            rd_shift <= '0;
        end else begin
            if (start)     cnt <= {4'd0, take};
            else if (take) cnt <= cnt + 5'd1;
            if (take)      sr  <= cur_byte[6:0];
            if (cmd_done) begin
                rw       <= cur_byte[7];
                addr     <= cur_byte[6:0];
                rd_shift <= rd_sel;
            end else if (state == DATA && rw && sclk_fall) begin
                rd_shift <= {rd_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            gain_a  <= 8'h00;
            gain_b  <= 8'h01 & 8'h00;
            ctrl    <= 8'h01;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (frame_done && !rw && addr <= 7'd2) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr;
                case (addr[1:0])
                    2'd0:    gain_a <= cur_byte;
                    2'd1:    gain_b <= cur_byte;
                    default: ctrl   <= cur_byte;
                endcase
            end
        end
    end

    // Output drive holds its last bit until the initiator deselects.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            sdo    <= 1'b0;
            sdo_oe <= 1'b0;
        end else if (csb_s) begin
            sdo    <= 1'b0;
            sdo_oe <= 1'b0;
        end else if (state == DATA && rw && sclk_fall) begin
            sdo    <= rd_shift[7];
            sdo_oe <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_8363.sv
// Randomized SPI frame bench for spi_slave_8363 with a register-map model.
module tb_spi_slave_8363;

    logic       main_clk = 1'b0;
    logic       rst      = 1'b0;
    logic       sclk     = 1'b0;
    logic       csb      = 1'b1;
    logic       sdi      = 1'b0;
    logic       sdo, sdo_oe, wr_stb;
    logic [7:0] gain_a, gain_b, ctrl;
    logic [6:0] wr_addr;

    int checks = 0;
    int errors = 0;
    int stb_cycles = 0;
    int oe_cycles  = 0;

    logic [7:0] mreg [0:2];
    int         exp_stb;
    logic [6:0] exp_waddr;

    spi_slave_8363 dut (
        .main_clk(main_clk),
        .rst     (rst),
        .sclk    (sclk),
        .csb     (csb),
        .sdi     (sdi),
        .sdo     (sdo),
        .sdo_oe  (sdo_oe),
        .gain_a  (gain_a),
        .gain_b  (gain_b),
        .ctrl    (ctrl),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr)
    );

    always #5 main_clk = ~main_clk;

    always @(negedge main_clk) begin
        if (wr_stb === 1'b1) stb_cycles++;
        if (sdo_oe === 1'b1) oe_cycles++;
    end

    task automatic model_reset();
        mreg[0]   = 8'h00;
        mreg[1]   = 8'h00;
        mreg[2]   = 8'h01;
        exp_stb   = stb_cycles;
        exp_waddr = 7'd0;
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (a <= 7'd2) return mreg[a];
        if (a == 7'd3) return 8'h63;
        return 8'h00;
    endfunction

    task automatic model_frame(input logic [15:0] f, input int nbits);
        if (nbits >= 16 && !f[15] && f[14:8] <= 7'd2) begin
            mreg[f[14:8]] = f[7:0];
            exp_stb++;
            exp_waddr = f[14:8];
        end
    endtask

    // sclk period is 8 main_clk cycles; sdo is sampled just before each rise.
    task automatic xfer(input logic [15:0] f, input int nbits, input bit simul,
                        input bit end_cs, output logic [7:0] rx,
                        output bit oe_ok);
        rx    = '0;
        oe_ok = 1'b1;
        if (!simul) begin
            csb = 1'b0;
            #80;
        end
        for (int i = 0; i < nbits; i++) begin
            sdi = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
            if (i == 0 && simul) csb = 1'b0;
            else #40;
            if (i >= 8 && i < 16) begin
                rx[15-i] = sdo;
                if (sdo_oe !== 1'b1) oe_ok = 1'b0;
            end
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
        #80;
        if (f[15] && nbits >= 16 && sdo_oe !== 1'b1) oe_ok = 1'b0;
        if (end_cs) begin
            csb = 1'b1;
            #80;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #50;
        checks++; if (gain_a !== 8'h00) begin errors++; $display("FAIL rst_gain_a got %h exp 00", gain_a); end
        checks++; if (gain_b !== 8'h00) begin errors++; $display("FAIL rst_gain_b got %h exp 00", gain_b); end
        checks++; if (ctrl !== 8'h01) begin errors++; $display("FAIL rst_ctrl got %h exp 01", ctrl); end
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL rst_wr_stb got %b exp 0", wr_stb); end
        checks++; if (wr_addr !== 7'd0) begin errors++; $display("FAIL rst_wr_addr got %h exp 0", wr_addr); end
        checks++; if (sdo !== 1'b0 || sdo_oe !== 1'b0) begin errors++; $display("FAIL rst_sdo got %b/%b exp 0/0", sdo, sdo_oe); end
        rst = 1'b1;
        #40;
        model_reset();
    endtask

    task automatic test_write_a();
        logic [7:0] rx;
        bit ok;
        int oe0 = oe_cycles;
        xfer(16'h005A, 16, 1'b0, 1'b1, rx, ok);
        model_frame(16'h005A, 16);
        checks++; if (gain_a !== 8'h5A) begin errors++; $display("FAIL wr_gain_a got %h exp 5a", gain_a); end
        checks++; if (stb_cycles !== exp_stb) begin errors++; $display("FAIL wr_stb_count got %0d exp %0d", stb_cycles, exp_stb); end
        checks++; if (wr_addr !== 7'd0) begin errors++; $display("FAIL wr_addr got %h exp 0", wr_addr); end
        checks++; if (oe_cycles !== oe0) begin errors++; $display("FAIL wr_oe_cycles got %0d exp %0d", oe_cycles - oe0, 0); end
    endtask

    task automatic test_read_id();
        logic [7:0] rx;
        bit ok;
        xfer(16'h8300, 16, 1'b0, 1'b1, rx, ok);
        checks++; if (rx !== 8'h63) begin errors++; $display("FAIL rd_id got %h exp 63", rx); end
        checks++; if (!ok) begin errors++; $display("FAIL rd_id_oe got 0 exp 1"); end
        checks++; if (sdo_oe !== 1'b0 || sdo !== 1'b0) begin errors++; $display("FAIL rd_id_release got %b/%b exp 0/0", sdo_oe, sdo); end
    endtask

    task automatic test_ctrl_rw();
        logic [7:0] rx;
        bit ok;
        xfer(16'h0277, 16, 1'b0, 1'b1, rx, ok);
        model_frame(16'h0277, 16);
        xfer(16'h8200, 16, 1'b0, 1'b1, rx, ok);
        checks++; if (ctrl !== 8'h77) begin errors++; $display("FAIL ctrl_wr got %h exp 77", ctrl); end
        checks++; if (rx !== 8'h77) begin errors++; $display("FAIL ctrl_rd got %h exp 77", rx); end
        xfer(16'h03FF, 16, 1'b0, 1'b1, rx, ok);
        model_frame(16'h03FF, 16);
        checks++; if (stb_cycles !== exp_stb) begin errors++; $display("FAIL id_wr_stb got %0d exp %0d", stb_cycles, exp_stb); end
        xfer(16'h8300, 16, 1'b0, 1'b1, rx, ok);
        checks++; if (rx !== 8'h63) begin errors++; $display("FAIL id_after_wr got %h exp 63", rx); end
        checks++; if (wr_addr !== 7'd2) begin errors++; $display("FAIL id_wr_addr got %h exp 2", wr_addr); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        bit ok;
        xfer(16'h01AA, 12, 1'b0, 1'b1, rx, ok);
        model_frame(16'h01AA, 12);
        checks++; if (gain_b !== 8'h00) begin errors++; $display("FAIL abort_gain_b got %h exp 00", gain_b); end
        checks++; if (stb_cycles !== exp_stb) begin errors++; $display("FAIL abort_stb got %0d exp %0d", stb_cycles, exp_stb); end
        xfer(16'h8000, 16, 1'b0, 1'b1, rx, ok);
        checks++; if (rx !== mreg[0] || !ok) begin errors++; $display("FAIL abort_next_rd got %h exp %h", rx, mreg[0]); end
    endtask

    task automatic test_extra_bits();
        logic [7:0] rx;
        bit ok;
        xfer(16'h0011, 20, 1'b0, 1'b1, rx, ok);
        model_frame(16'h0011, 20);
        checks++; if (gain_a !== 8'h11) begin errors++; $display("FAIL extra_gain_a got %h exp 11", gain_a); end
        checks++; if (stb_cycles !== exp_stb) begin errors++; $display("FAIL extra_stb got %0d exp %0d", stb_cycles, exp_stb); end
        checks++; if (gain_b !== mreg[1] || ctrl !== mreg[2]) begin errors++; $display("FAIL extra_others got %h/%h exp %h/%h", gain_b, ctrl, mreg[1], mreg[2]); end
    endtask

    task automatic test_simul_start();
        logic [7:0] rx;
        bit ok;
        xfer(16'h0244, 16, 1'b1, 1'b1, rx, ok);
        model_frame(16'h0244, 16);
        checks++; if (ctrl !== 8'h44) begin errors++; $display("FAIL simul_ctrl got %h exp 44", ctrl); end
        xfer(16'h8200, 16, 1'b1, 1'b1, rx, ok);
        checks++; if (rx !== 8'h44 || !ok) begin errors++; $display("FAIL simul_rd got %h exp 44", rx); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        bit ok;
        xfer(16'h00CC, 10, 1'b0, 1'b0, rx, ok);
        rst = 1'b0;
        #20;
        checks++; if (gain_a !== 8'h00 || ctrl !== 8'h01) begin errors++; $display("FAIL mid_rst_async got %h/%h exp 00/01", gain_a, ctrl); end
        csb  = 1'b1;
        sclk = 1'b0;
        #20;
        rst = 1'b1;
        #40;
        model_reset();
        xfer(16'h0133, 16, 1'b0, 1'b1, rx, ok);
        model_frame(16'h0133, 16);
        checks++; if (gain_b !== 8'h33) begin errors++; $display("FAIL mid_gain_b got %h exp 33", gain_b); end
        checks++; if (gain_a !== 8'h00 || ctrl !== 8'h01) begin errors++; $display("FAIL mid_others got %h/%h exp 00/01", gain_a, ctrl); end
        checks++; if (wr_addr !== 7'd1 || stb_cycles !== exp_stb) begin errors++; $display("FAIL mid_stb got %h/%0d exp 1/%0d", wr_addr, stb_cycles, exp_stb); end
    endtask

    task automatic test_random();
        logic [7:0]  rx;
        logic [15:0] f;
        logic [6:0]  a;
        logic [7:0]  exp_rd;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
            f = {1'($urandom_range(0, 1)), a, 8'($urandom)};
            exp_rd = model_read(a);
            xfer(f, 16, 1'($urandom_range(0, 3) == 0), 1'b1, rx, ok);
            model_frame(f, 16);
            if (f[15]) begin
                checks++; if (rx !== exp_rd || !ok) begin errors++; $display("FAIL rnd_rd f=%h got %h oe=%b exp %h", f, rx, ok, exp_rd); end
            end
            checks++; if (gain_a !== mreg[0] || gain_b !== mreg[1] || ctrl !== mreg[2]) begin
                errors++; $display("FAIL rnd_regs f=%h got %h %h %h exp %h %h %h", f, gain_a, gain_b, ctrl, mreg[0], mreg[1], mreg[2]);
            end
            checks++; if (stb_cycles !== exp_stb || wr_addr !== exp_waddr) begin
                errors++; $display("FAIL rnd_stb f=%h got %0d/%h exp %0d/%h", f, stb_cycles, wr_addr, exp_stb, exp_waddr);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_write_a();
        test_read_id();
        test_ctrl_rw();
        test_abort();
        test_extra_bits();
        test_simul_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
